// File: rtl/mem_stage_param.sv
// Memory-access pipeline stage: sits between EX and WB, owns a word-addressed
// synchronous data memory and registers the write-back bundle. Loads take
// MEM_LAT cycles and stall upstream while they are in flight.
module mem_stage_param #(
    parameter int              DATA_W  = 32,
    parameter int              REG_W   = 7,
    parameter int              OP_W    = 5,
    parameter int              ADDR_W  = 10,
    parameter int              MEM_LAT = 2,
    parameter logic [OP_W-1:0] OP_LD   = 5'd6,
    parameter logic [OP_W-1:0] OP_ST   = 5'd7,
    parameter logic [OP_W-1:0] OP_BR   = 5'd8,
    parameter logic [OP_W-1:0] OP_NOP  = 5'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   OpCode,
    input  logic [REG_W-1:0]  RdOut,
    input  logic [DATA_W-1:0] AluResult,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [DATA_W-1:0] branchResult,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] Result,
    output logic [REG_W-1:0]  RdWb,
    output logic              WrEnable,
    output logic [DATA_W-1:0] BranchResultOut,
    output logic              fault
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam int                CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_W-1:0]    ld_rd_q, ld_rd_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [REG_W-1:0]    rd_wb_q, rd_wb_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   br_q, br_d;
    logic                out_valid_q, out_valid_d;
    logic                fault_q, fault_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic                mem_re;

    logic                accept;
    logic                is_ld, is_st, is_br, is_nop, aligned;

    // Decode the incoming EX bundle and derive the memory access strobes.
    always_comb begin
        accept   = in_valid && (state_q == ST_IDLE);
        is_ld    = (OpCode == OP_LD);
        is_st    = (OpCode == OP_ST);
        is_br    = (OpCode == OP_BR);
        is_nop   = (OpCode == OP_NOP);
        aligned  = (AluResult[1:0] == 2'b00);
        // Upper address bits are dropped, so accesses wrap modulo DEPTH.
        mem_addr = AluResult[ADDR_W+1:2];
        mem_we   = accept && is_st && aligned;
        mem_re   = accept && is_ld && aligned;
    end

    // Data memory with a registered read port; the read is issued on the
    // accepting edge, so a store on the previous edge is already visible.
    // NOTE: memory arrays carry no reset so they map onto RAM macros; only
    // control state is reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= StoreData;
        end
        if (mem_re) begin
            rdata_q <= mem[mem_addr];
        end
    end

    // Next-state and write-back bundle logic for the IDLE/WAIT load FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_rd_d     = ld_rd_q;
        result_d    = result_q;
        rd_wb_d     = rd_wb_q;
        br_d        = br_q;
        out_valid_d = 1'b0;
        wr_en_d     = 1'b0;
        fault_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if ((is_ld || is_st) && !aligned) begin
                        // Misaligned LD/ST: no memory access, report a fault.
                        out_valid_d = 1'b1;
                        fault_d     = 1'b1;
                        result_d    = AluResult;
                        rd_wb_d     = RdOut;
                        br_d        = '0;
                    end else if (is_ld) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                        ld_rd_d = RdOut;
                    end else if (is_st) begin
                        out_valid_d = 1'b1;
                        br_d        = '0;
                    end else if (is_br) begin
                        out_valid_d = 1'b1;
                        br_d        = branchResult;
                    end else if (!is_nop) begin
                        out_valid_d = 1'b1;
                        result_d    = AluResult;
                        rd_wb_d     = RdOut;
                        wr_en_d     = (RdOut != '0);
                        br_d        = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = rdata_q;
                    rd_wb_d     = ld_rd_q;
                    wr_en_d     = (ld_rd_q != '0);
                    br_d        = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any pending load.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ld_rd_q     <= '0;
            result_q    <= '0;
            rd_wb_q     <= '0;
            wr_en_q     <= 1'b0;
            br_q        <= '0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_rd_q     <= ld_rd_d;
            result_q    <= result_d;
            rd_wb_q     <= rd_wb_d;
            wr_en_q     <= wr_en_d;
            br_q        <= br_d;
            out_valid_q <= out_valid_d;
            fault_q     <= fault_d;
        end
    end

    assign stall           = (state_q == ST_WAIT);
    assign out_valid       = out_valid_q;
    assign Result          = result_q;
    assign RdWb            = rd_wb_q;
    assign WrEnable        = wr_en_q;
    assign BranchResultOut = br_q;
    assign fault           = fault_q;

endmodule

// File: doc/mem_stage_param.md
# mem_stage_param

Parametrised memory-access pipeline stage for the grupal processor, the successor of the fixed 32-bit combinational `MEM` stage. It sits between EX and WB. It owns a word-addressed synchronous data memory and registers the write-back bundle (`Result`, `RdWb`, `WrEnable`, `BranchResultOut`). Loads take a configurable multi-cycle latency, during which the stage stalls upstream.

## Interface
Parameters:
- DATA_W, 32, datapath and memory word width
- REG_W, 7, destination register index width
- OP_W, 5, opcode width
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W words
- MEM_LAT, 2, load latency in cycles (legal range >= 1)
- OP_LD, 5'd6, load opcode
- OP_ST, 5'd7, store opcode
- OP_BR, 5'd8, branch opcode
- OP_NOP, 5'd0, no-operation opcode

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  EX bundle valid this cycle
- OpCode  in  OP_W  operation
- RdOut  in  REG_W  destination register from EX
- AluResult  in  DATA_W  ALU result / byte address for LD/ST
- StoreData  in  DATA_W  store data
- branchResult  in  DATA_W  branch target from EX
- stall  out  1  upstream must hold its inputs (combinational, high only in WAIT)
- out_valid  out  1  write-back bundle valid
- Result  out  DATA_W  write-back data
- RdWb  out  REG_W  write-back register
- WrEnable  out  1  register-file write enable
- BranchResultOut  out  DATA_W  branch target (OP_BR only; 0 otherwise)
- fault  out  1  one-cycle pulse on a misaligned LD/ST

## Operation
- An input is accepted on an edge where in_valid=1 and stall=0. Inputs are ignored while stall=1.
- Word address is AluResult[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo depth.
- Misaligned access (AluResult[1:0]!=0 on LD/ST):
  - no memory access takes place;
  - out_valid=1, WrEnable=0, fault=1 for one cycle;
  - Result and RdWb are updated as for an ALU op.
- ALU ops (any opcode other than LD, ST, BR, NOP):
  - Result=AluResult, RdWb=RdOut;
  - WrEnable=(RdOut!=0), since register 0 is never written.
- OP_ST: mem[addr]<=StoreData on the accepting edge; WrEnable=0, out_valid=1.
- OP_LD: issues a synchronous read and enters WAIT; Result=mem[addr], WrEnable=(RdOut!=0).
- OP_BR: BranchResultOut=branchResult, WrEnable=0, out_valid=1.
- OP_NOP, or no accepted input: out_valid=0, WrEnable=0, fault=0; Result, RdWb and BranchResultOut hold their values.
- FSM, two states:
  - IDLE -> WAIT on an accepted aligned LD; the counter loads MEM_LAT-1.
  - WAIT decrements the counter each cycle.
  - When counter==0, the next edge registers read data and returns to IDLE.
- Reset values: state=IDLE, counter=0, stall=0, out_valid=0, WrEnable=0, fault=0, Result=0, RdWb=0, BranchResultOut=0.
- Memory contents are not reset.

## Timing
- Non-load ops accepted at edge k: bundle visible after edge k (1-cycle latency). Full throughput with back-to-back issue.
- Load accepted at edge k:
  - stall=1 for exactly MEM_LAT cycles, from after edge k until edge k+MEM_LAT;
  - out_valid=1 and Result valid after edge k+MEM_LAT;
  - stall drops in that same cycle, so the next op is accepted at edge k+MEM_LAT+1... it is accepted on the first edge where stall=0.
- Store at edge k followed by a load from the same address accepted at edge k+1 returns the stored data; there is no stale read.
- Reset asserted mid-WAIT:
  - FSM returns to IDLE immediately and the pending load is discarded;
  - all outputs take their reset values asynchronously;
  - memory keeps its contents.
- fault, out_valid and WrEnable are single-cycle per accepted op; they are never held across idle cycles.

## Test plan
- Reset, then ALU op with OpCode=3, AluResult=2, RdOut=5 -> after 1 edge: Result=2, RdWb=5, WrEnable=1, out_valid=1, stall=0.
- ST with AluResult=0x10, StoreData=0xDEADBEEF, then LD with AluResult=0x10, RdOut=9 (MEM_LAT=2):
  - stall=1 for 2 cycles;
  - then Result=0xDEADBEEF, RdWb=9, WrEnable=1.
- LD with AluResult=0x12 -> fault=1 and WrEnable=0 for one cycle, no stall, memory unchanged.
- ALU op with RdOut=0, AluResult=7 -> Result=7, WrEnable=0. BR with branchResult=0x40 -> BranchResultOut=0x40, WrEnable=0.
- Address wrap with ADDR_W=10: ST to 0x1000 (word 1024), then LD from 0x0 -> returns the stored data.
- Assert rst one cycle into a load's WAIT -> stall=0, out_valid=0, Result=0 immediately; the next ALU op completes with normal 1-cycle latency.
